// File: rtl/oled_dec_formatter.sv
// oled_dec_formatter: converts a 16-bit value to four ASCII decimal chars
// with an iterative double-dabble, then offers the result over req/ack.
// A new conversion starts when the value changes or a refresh is forced.
module oled_dec_formatter #(
    parameter bit         BLANK_LZ = 1'b1,
    parameter logic [7:0] OVF_CHAR = 8'h2D
) (
    input  logic        clk_50m,
    input  logic        rst,
    input  logic [15:0] value_in,
    input  logic        force_req,
    output logic [31:0] ascii_out,
    output logic        out_req,
    input  logic        out_ack,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, FORMAT, HOLD} state_t;

    state_t      state;
    logic [15:0] last_value;
    logic        force_pend;
    logic [15:0] shreg;
    logic [15:0] bcd;
    logic [4:0]  bitcnt;
    logic        ovf;

    logic [15:0] bcd_adj;
    logic [31:0] ascii_fmt;
    logic [3:0]  d3, d2, d1, d0;
    logic        lz3, lz2, lz1;

    // Double-dabble correction: add 3 to any BCD nibble of 5 or more before the shift
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // BCD to ASCII, optionally blanking leading zeros; units digit always shown
    always_comb begin
        d3  = bcd[15:12];
        d2  = bcd[11:8];
        d1  = bcd[7:4];
        d0  = bcd[3:0];
        lz3 = BLANK_LZ && (d3 == 4'd0);
        lz2 = lz3 && (d2 == 4'd0);
        lz1 = lz2 && (d1 == 4'd0);
        ascii_fmt[31:24] = lz3 ? 8'h20 : {4'h3, d3};
        ascii_fmt[23:16] = lz2 ? 8'h20 : {4'h3, d2};
        ascii_fmt[15:8]  = lz1 ? 8'h20 : {4'h3, d1};
        ascii_fmt[7:0]   = {4'h3, d0};
    end

    assign busy = (state != IDLE);

    // Conversion FSM with registered outputs
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_value <= 16'd0;
            force_pend <= 1'b1;
            shreg      <= 16'd0;
            bcd        <= 16'd0;
            bitcnt     <= 5'd0;
            ovf        <= 1'b0;
            ascii_out  <= 32'h20202020;
            out_req    <= 1'b0;
        end else begin
            // Sticky refresh request; the capture edge below absorbs it
            if (force_req)
                force_pend <= 1'b1;
            case (state)
                IDLE: begin
                    if (value_in != last_value || force_pend) begin
                        last_value <= value_in;
                        shreg      <= value_in;
                        bcd        <= 16'd0;
                        bitcnt     <= 5'd0;
                        force_pend <= 1'b0;
                        ovf        <= (value_in > 16'd9999);
                        // Overflow skips the shifts: the display is fixed anyway
                        state      <= (value_in > 16'd9999) ? FORMAT : SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd, shreg} <= {bcd_adj, shreg} << 1;
                    bitcnt       <= bitcnt + 5'd1;
                    if (bitcnt == 5'd15)
                        state <= FORMAT;
                end
                FORMAT: begin
                    ascii_out <= ovf ? {4{OVF_CHAR}} : ascii_fmt;
                    out_req   <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ack) begin
                        out_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oled_dec_formatter.sv
// Self-checking bench for oled_dec_formatter: expected strings are queued
// when stimulus is applied and compared at each completed handshake.
module tb_oled_dec_formatter;

    logic        clk_50m = 1'b0;
    logic        rst;
    logic [15:0] value_in;
    logic        force_req;
    logic [31:0] ascii_out;
    logic        out_req;
    logic        out_ack;
    logic        busy;

    logic [31:0] ascii_z;
    logic        req_z;
    logic        busy_z;

    int errors = 0;
    int checks = 0;
    logic [31:0] sb[$];

    oled_dec_formatter dut (
        .clk_50m(clk_50m), .rst(rst), .value_in(value_in), .force_req(force_req),
        .ascii_out(ascii_out), .out_req(out_req), .out_ack(out_ack), .busy(busy)
    );

    // Zero-padded variant, always acknowledging
    oled_dec_formatter #(.BLANK_LZ(1'b0)) dut_z (
        .clk_50m(clk_50m), .rst(rst), .value_in(value_in), .force_req(force_req),
        .ascii_out(ascii_z), .out_req(req_z), .out_ack(1'b1), .busy(busy_z)
    );

    always #10 clk_50m = ~clk_50m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_50m);
        #1;
    endtask

    // Count edges until out_req rises; also tally cycles where busy was low
    task automatic wait_req(output int n, output int busy_bad);
        n = 0;
        busy_bad = 0;
        while (!out_req && n < 200) begin
            step();
            n++;
            if (!busy) busy_bad++;
        end
    endtask

    // Scoreboard: compare at every accepted result
    always @(negedge clk_50m) begin
        if (!rst && out_req && out_ack) begin
            if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
            else chk("sb_ascii", ascii_out, sb.pop_front());
        end
    end

    initial begin
        int n, bb, bad;
        rst = 1'b1; value_in = 16'd0; force_req = 1'b0; out_ack = 1'b1;
        step(); step();
        chk("rst_ascii", ascii_out, 32'h20202020);
        chk("rst_req", {31'd0, out_req}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // Reset release converts the current value thanks to the pending refresh
        sb.push_back(32'h20202030);
        rst = 1'b0;
        wait_req(n, bb);
        chk("lat_reset", n, 18);
        step();

        // Plain four-digit value
        value_in = 16'd1234; sb.push_back(32'h31323334);
        wait_req(n, bb);
        chk("lat_1234", n, 18);
        chk("busy_1234", bb, 0);
        step();

        // Single digit, then forced refresh with an unchanged value
        value_in = 16'd7; sb.push_back(32'h20202037);
        wait_req(n, bb);
        chk("lat_7", n, 18);
        step();
        force_req = 1'b1; sb.push_back(32'h20202037);
        step();
        force_req = 1'b0;
        wait_req(n, bb);
        chk("lat_force", n, 18);
        step();
        chk("zpad_7", ascii_z, 32'h30303037);

        // Force together with a value change yields one conversion
        value_in = 16'd8; force_req = 1'b1; sb.push_back(32'h20202038);
        step();
        force_req = 1'b0;
        wait_req(n, bb);
        chk("lat_8", n, 17);
        step();
        repeat (40) step();
        chk("one_conv", {31'd0, out_req}, 32'd0);

        // Overflow values bypass the shift phase
        value_in = 16'd10000; sb.push_back(32'h2D2D2D2D);
        wait_req(n, bb);
        chk("lat_ovf1", n, 2);
        step();
        value_in = 16'hFFFF; sb.push_back(32'h2D2D2D2D);
        wait_req(n, bb);
        chk("lat_ovf2", n, 2);
        step();

        // Held result while the consumer stalls and the value keeps moving
        out_ack = 1'b0;
        value_in = 16'd90; sb.push_back(32'h20203930);
        wait_req(n, bb);
        chk("lat_90", n, 18);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (i == 10) value_in = 16'd100;
            if (i == 50) value_in = 16'd900;
            if (ascii_out !== 32'h20203930 || !out_req) bad++;
        end
        chk("hold_stable", bad, 0);
        sb.push_back(32'h20393030);
        out_ack = 1'b1;
        step();
        wait_req(n, bb);
        chk("lat_900", n, 18);
        step();
        repeat (40) step();
        chk("only_final", {31'd0, out_req}, 32'd0);

        // Asynchronous reset in the middle of the shift phase
        value_in = 16'd9999;
        step();
        repeat (8) step();
        #3;
        rst = 1'b1;
        #1;
        chk("mid_ascii", ascii_out, 32'h20202020);
        chk("mid_req", {31'd0, out_req}, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        step();
        sb.push_back(32'h39393939);
        rst = 1'b0;
        wait_req(n, bb);
        chk("lat_9999", n, 18);
        step();
        repeat (5) step();
        chk("sb_left", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
